// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, RCON, S-box and the combinational round primitives.
// Bytes are numbered from the MSB: byte i = block[127-8i -: 8], state[r][c] = byte 4c+r.
package aes_pkg;

    localparam int unsigned AES_ROUNDS = 10;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Row n of the literal holds S-box entries 16n .. 16n+15.
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        if (idx >= 4'd1 && idx <= 4'd10) begin
            r = RCON[idx];
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TAB[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic block_t sub_bytes(input block_t b);
        block_t o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = sbox(b[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic block_t shift_rows(input block_t b);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = b[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic block_t mix_columns(input block_t b);
        block_t     o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = b[127 - 32 * c -: 8];
            a1 = b[119 - 32 * c -: 8];
            a2 = b[111 - 32 * c -: 8];
            a3 = b[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one and RCON.
module aes_key_step (
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_n
);
    import aes_pkg::*;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk;

    // SubWord(RotWord(w3)) ^ {rcon, 24'h0}
    assign t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon, 24'h000000};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_n = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock on a shared round datapath,
// with valid/ready on both the plaintext/key input and the ciphertext output.
module aes_round_ctrl #(
    parameter int unsigned ROUNDS = 10,
    parameter int unsigned RIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      plaintext,
    input  logic [127:0]      key,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      ciphertext,
    output logic              busy,
    output logic [RIDX_W-1:0] round_idx
);
    import aes_pkg::*;

    if (ROUNDS != AES_ROUNDS) begin : g_rounds_check
        $error("aes_round_ctrl: ROUNDS must be %0d (AES-128)", AES_ROUNDS);
    end
    if (RIDX_W != 4) begin : g_ridx_check
        $error("aes_round_ctrl: RIDX_W must be 4");
    end

    state_t            state;
    block_t            st;
    block_t            rk;
    block_t            rk_n;
    logic [RIDX_W-1:0] rnd;

    block_t sb_out;
    block_t sr_out;
    block_t mc_out;
    block_t round_out;
    logic   last_round;

    assign last_round = (rnd == RIDX_W'(ROUNDS));

    assign sb_out    = sub_bytes(st);
    assign sr_out    = shift_rows(sb_out);
    assign mc_out    = mix_columns(sr_out);
    // Final round skips MixColumns.
    assign round_out = (last_round ? sr_out : mc_out) ^ rk_n;

    aes_key_step u_key_step (
        .rk   (rk),
        .rcon (rcon_of(rnd[3:0])),
        .rk_n (rk_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            st        <= '0;
            rk        <= '0;
            rnd       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // abort outranks a simultaneous request
                    if (in_valid && !abort) begin
                        st       <= plaintext ^ key;
                        rk       <= key;
                        rnd      <= RIDX_W'(1);
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        rnd      <= '0;
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        st <= round_out;
                        rk <= rk_n;
                        if (last_round) begin
                            rnd       <= '0;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            rnd <= rnd + RIDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (abort || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    rnd       <= '0;
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign ciphertext = st;
    assign round_idx  = rnd;

endmodule
